// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader driving the instruction memory write port
//
// Receives a program image as a byte stream and writes it into a writable
// instruction memory one 32-bit word at a time, starting at byte address 0.
// Stream: 0xA5 magic, N[7:0], N[15:8] (word count), then 4*N little-endian
// data bytes. The core is held in reset (cpu_rst) while a load is in progress.
//
// Optional feature macro: IMEM_LOADER_CSUM_EN
//   When defined, one extra byte follows the data: the XOR of all 4*N data
//   bytes (0x00 for N == 0). A mismatch fails the load.
//
// Ports:
//   clk       in   1           single clock
//   rst       in   1           synchronous, active-high reset
//   rx_data   in   8           received byte
//   rx_valid  in   1           rx_data valid this cycle
//   rx_ready  out  1           loader accepts a byte (transfer = rx_valid & rx_ready)
//   w_en      out  1           one-cycle imem write strobe
//   w_addr    out  ADDR_WIDTH  imem byte address, bits [1:0] always 0
//   w_data    out  DATA_WIDTH  word to write
//   cpu_rst   out  1           hold-in-reset to the core
//   busy      out  1           load in progress (any state except IDLE)
//   done      out  1           one-cycle pulse: load completed successfully
//   err       out  1           sticky: last load failed; cleared by the next magic byte

module imem_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 13,
    parameter int WORD_NUM    = (2**ADDR_WIDTH) / 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int         TW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN0   = 3'd1;
    localparam logic [2:0] S_LEN1   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd6;
`endif

    logic [2:0]            r_state;
    logic                  r_rx_ready;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cpu_rst;
    logic                  r_err;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [15:0]           r_word_idx;
    logic [1:0]            r_bcnt;
    // Holds the first three bytes of the word being assembled; the fourth
    // byte goes straight into the write register, so a new word can start
    // packing while the previous one is still on the write port.
    logic [23:0]           r_shift;
    logic [TW-1:0]         r_idle;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]            r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_timed_out;
    logic        w_last_word;
    logic        w_waiting;
    logic [2:0]  w_next_state;
    logic [2:0]  w_end_state;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_len       = {rx_data, r_len_lo};
    assign w_timed_out = (r_idle == TW'(TIMEOUT_CYC - 1));
    assign w_last_word = (r_word_idx == (r_len - 16'd1));

`ifdef IMEM_LOADER_CSUM_EN
    assign w_waiting   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    // Where the load goes once all words are written (or N == 0).
    assign w_end_state = S_CSUM;
`else
    assign w_waiting   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA);
    assign w_end_state = S_FINISH;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && rx_data == MAGIC) begin
                    w_next_state = S_LEN0;
                end
            end
            S_LEN0: begin
                if (w_accept) begin
                    w_next_state = S_LEN1;
                end else if (w_timed_out) begin
                    w_next_state = S_FAIL;
                end
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (w_len == 16'd0) begin
                        w_next_state = w_end_state;
                    end else if ({1'b0, w_len} > 17'(WORD_NUM)) begin
                        // Rejecting oversize images here is what keeps the
                        // write address from ever wrapping.
                        w_next_state = S_FAIL;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end else if (w_timed_out) begin
                    w_next_state = S_FAIL;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_bcnt == 2'd3 && w_last_word) begin
                        w_next_state = w_end_state;
                    end
                end else if (w_timed_out) begin
                    w_next_state = S_FAIL;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_next_state = (rx_data == r_csum) ? S_FINISH : S_FAIL;
                end else if (w_timed_out) begin
                    w_next_state = S_FAIL;
                end
            end
`endif
            S_FINISH: w_next_state = S_IDLE;
            S_FAIL:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_cpu_rst  <= 1'b0;
            r_err      <= 1'b0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_idle     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_rx_ready <= 1'b1;
            r_wen      <= 1'b0;
            r_state    <= w_next_state;

            // Idle counter only runs while a load waits for its next byte.
            if (w_waiting && !w_accept) begin
                r_idle <= r_idle + 1'b1;
            end else begin
                r_idle <= '0;
            end

            if (w_next_state == S_FAIL && r_state != S_FAIL) begin
                r_err <= 1'b1;
            end
            // Core is released in the same cycle done is shown.
            if (w_next_state == S_FINISH) begin
                r_cpu_rst <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && rx_data == MAGIC) begin
                        r_err      <= 1'b0;
                        r_cpu_rst  <= 1'b1;
                        r_word_idx <= '0;
                        r_bcnt     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= rx_data;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len <= w_len;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shift <= {rx_data, r_shift[23:8]};
                        r_bcnt  <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum  <= r_csum ^ rx_data;
`endif
                        if (r_bcnt == 2'd3) begin
                            r_wen      <= 1'b1;
                            r_waddr    <= {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
                            r_wdata    <= {rx_data, r_shift};
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign w_en     = r_wen;
    assign w_addr   = r_waddr;
    assign w_data   = r_wdata;
    assign cpu_rst  = r_cpu_rst;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FINISH);

endmodule
